matrix_drain_ctrl: RTL and testbench
====================================

Name: matrix_drain_ctrl

Overview:
Sequences readout of the N x N result matrix from the result buffer and streams each 32-bit element to the file-writer datapath over a strobe/acknowledge handshake. It generates buffer read addresses, captures read data, holds each value stable until the writer accepts it, and signals completion. It sits between the multiplier's result buffer and the output writer. It replaces the writer's free-running delay-based timing with a real flow-controlled sequence.

Parameters:
N, 8, matrix dimension; legal range 1..31.
IDX_W, 5, width of the row and column index ports.
DATA_W, 32, element width (IEEE-754 single).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  request a drain; sampled only in S_IDLE.
cfg_transpose  in  1  0 = row-major order, 1 = column-major order; latched on an accepted start.
rd_en  out  1  one-cycle read strobe to the result buffer.
rd_row  out  IDX_W  buffer row address (i).
rd_col  out  IDX_W  buffer column address (j).
rd_data  in  DATA_W  buffer read data, valid exactly 1 cycle after rd_en.
value  out  DATA_W  element presented to the writer.
value_stb  out  1  value valid.
value_ack  in  1  writer accepts value when value_stb and value_ack are both high in the same cycle.
busy  out  1  high from an accepted start until done.
done  out  1  one-cycle pulse after the last element is accepted.
count  out  2*IDX_W  number of elements accepted in the current drain.

Behaviour:
- Reset: on rst_n low at a clock edge, go to S_IDLE. All outputs are 0: rd_en, rd_row, rd_col, value, value_stb, busy, done, count. The latched transpose bit is 0. Reset has this effect in every state, including mid-drain; a partial drain is abandoned with no done pulse.
- States: S_IDLE -> S_READ -> S_CAPT -> S_SEND -> (S_READ | S_DONE) -> S_IDLE.
- S_IDLE: on start=1, latch cfg_transpose, clear i, j and count, set busy=1, go to S_READ.
- S_READ: assert rd_en for exactly one cycle with rd_row=i, rd_col=j; go to S_CAPT.
- S_CAPT: register rd_data into value; assert value_stb; go to S_SEND.
- S_SEND: hold value_stb=1 and value unchanged until the handshake completes.
  - On value_stb and value_ack both high: deassert value_stb on the next cycle and increment count.
  - Advance the indices. Row-major: j++, and on j==N-1 wrap j to 0 and i++. Column-major: i++, and on i==N-1 wrap i to 0 and j++.
  - If the accepted element was the last one (i==N-1 and j==N-1 in both orders), go to S_DONE; otherwise go to S_READ.
- S_DONE: done=1 for one cycle, busy=0, go to S_IDLE. count holds N*N until the next accepted start.
- value_ack outside S_SEND is ignored. A start asserted while busy is ignored and not queued.
- Minimum cost is 3 cycles per element (read, capture, send with immediate ack). First rd_en occurs 1 cycle after the accepted start. A full drain with ack always high takes 3*N*N + 2 cycles from start to done.
- rd_row and rd_col hold their last values outside S_READ; they are only meaningful when rd_en is high.
- count is 2*IDX_W bits wide; N*N <= 961 fits without overflow.
- N=1: one read, one send, then done.

Decomposition:
- Shared package (matrix_pkg): state encoding constants (S_IDLE, S_READ, S_CAPT, S_SEND, S_DONE, 3-bit), DATA_W, and the default IDX_W. The multiplier and writer reuse these.
- Natural sub-module: idx_walker. It holds i and j, and provides the row/column-major advance and the last-element flag, driven by an advance pulse and the latched transpose bit. The FSM stays in the top module.

Test Plan:
- N=2, row-major, value_ack tied high, buffer[i][j] = 10*i+j -> writer receives 0, 1, 10, 11 in order; done pulses once at cycle 14 after start; count=4.
- N=2, cfg_transpose=1 -> received order is 0, 10, 1, 11; rd_row/rd_col sequence is (0,0), (1,0), (0,1), (1,1).
- Backpressure: hold value_ack low for 5 cycles on the second element -> value_stb stays high and value stays stable for all 5 cycles; no new rd_en is issued; the order is unchanged.
- Second start pulse mid-drain -> ignored; exactly N*N elements are sent and exactly one done pulse is produced.
- rst_n low for one cycle during S_SEND of element 3 -> next cycle all outputs are 0, state is S_IDLE, no done pulse; a fresh start drains from (0,0).
- N=1, buffer = 32'h3F800000 -> one transfer of 3F800000; done is asserted 1 cycle after the ack; count=1.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier, its result-buffer drain and the writer.
// Holds the drain FSM encoding and the default element and index widths.
package matrix_pkg;

  localparam int MATRIX_DATA_W = 32;
  localparam int MATRIX_IDX_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } drain_state_t;

endpackage

// File: rtl/matrix_drain_ctrl_idx_walker.sv
// Row/column index walker for the drain sequence: clears on a new drain and
// steps through the N x N matrix in row-major or column-major order.
module idx_walker #(
  parameter int N     = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic             transpose,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (transpose) begin
        if (row == MAX_IDX) begin
          row <= '0;
          col <= col + IDX_ONE;
        end else begin
          row <= row + IDX_ONE;
        end
      end else begin
        if (col == MAX_IDX) begin
          col <= '0;
          row <= row + IDX_ONE;
        end else begin
          col <= col + IDX_ONE;
        end
      end
    end
  end

  // The final element is (N-1, N-1) in both orders.
  assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/matrix_drain_ctrl.sv
// Drains the N x N result buffer to the file writer one element at a time,
// using a one-cycle buffer read and a strobe/acknowledge handshake per element.
module matrix_drain_ctrl
  import matrix_pkg::*;
#(
  parameter int N      = 8,
  parameter int IDX_W  = MATRIX_IDX_W,
  parameter int DATA_W = MATRIX_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cfg_transpose,
  output logic                 rd_en,
  output logic [IDX_W-1:0]     rd_row,
  output logic [IDX_W-1:0]     rd_col,
  input  logic [DATA_W-1:0]    rd_data,
  output logic [DATA_W-1:0]    value,
  output logic                 value_stb,
  input  logic                 value_ack,
  output logic                 busy,
  output logic                 done,
  output logic [2*IDX_W-1:0]   count,
  output logic [2:0]           dbg_state
);

  localparam int CNT_W = 2 * IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  drain_state_t state, state_nxt;
  logic         transpose_q;
  logic         accept_start;
  logic         advance;
  logic         handshake;
  logic         last_elem;

  // Writer handshake: value is valid while value_stb is high and is held
  // unchanged until the cycle in which value_ack is also high; that cycle
  // transfers the element and value_stb drops on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    advance      = 1'b0;
    handshake    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = S_READ;
        end
      end
      S_READ: state_nxt = S_CAPT;
      S_CAPT: state_nxt = S_SEND;
      S_SEND: begin
        if (value_ack) begin
          handshake = 1'b1;
          // Indices stay on the last element so rd_row/rd_col keep their value.
          advance   = !last_elem;
          state_nxt = last_elem ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_en     = (state == S_READ);
  assign value_stb = (state == S_SEND);
  assign busy      = (state == S_READ) || (state == S_CAPT) || (state == S_SEND);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      transpose_q <= 1'b0;
      value       <= '0;
      count       <= '0;
    end else begin
      if (accept_start) begin
        transpose_q <= cfg_transpose;
        count       <= '0;
      end
      if (state == S_CAPT) begin
        value <= rd_data;
      end
      if (handshake) begin
        count <= count + CNT_ONE;
      end
    end
  end

  idx_walker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept_start),
    .advance   (advance),
    .transpose (transpose_q),
    .row       (rd_row),
    .col       (rd_col),
    .last      (last_elem)
  );

endmodule

// File: tb/tb_matrix_drain_ctrl.sv
// Bench for matrix_drain_ctrl: an N=2 instance with a 10*i+j buffer model and
// an N=1 instance holding 1.0f, checked against expected-value queues.
module tb_matrix_drain_ctrl;
  import matrix_pkg::*;

  localparam int NN = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   acc_cnt = 0;

  // N=2 instance
  logic        start, cfg_transpose, rd_en, value_stb, value_ack, busy, done;
  logic [4:0]  rd_row, rd_col;
  logic [31:0] rd_data = '0, value;
  logic [9:0]  count;
  logic [2:0]  dbg_state;

  // N=1 instance
  logic        start_1, cfg_transpose_1, rd_en_1, value_stb_1, value_ack_1, busy_1, done_1;
  logic [4:0]  rd_row_1, rd_col_1;
  logic [31:0] rd_data_1 = '0, value_1;
  logic [9:0]  count_1;
  logic [2:0]  dbg_state_1;

  logic [31:0] exp_q[$];
  logic [9:0]  addr_q[$];
  logic [31:0] exp1_q[$];

  matrix_drain_ctrl #(.N(2), .IDX_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_transpose(cfg_transpose),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .value(value), .value_stb(value_stb), .value_ack(value_ack),
    .busy(busy), .done(done), .count(count), .dbg_state(dbg_state)
  );

  matrix_drain_ctrl #(.N(1), .IDX_W(5), .DATA_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .cfg_transpose(cfg_transpose_1),
    .rd_en(rd_en_1), .rd_row(rd_row_1), .rd_col(rd_col_1), .rd_data(rd_data_1),
    .value(value_1), .value_stb(value_stb_1), .value_ack(value_ack_1),
    .busy(busy_1), .done(done_1), .count(count_1), .dbg_state(dbg_state_1)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] elem(input int i, input int j);
    return 32'(10 * i + j);
  endfunction

  // buffer models: data valid one cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) rd_data <= elem(int'(rd_row), int'(rd_col));
    if (rd_en_1) rd_data_1 <= 32'h3F80_0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor for the N=2 instance
  always @(negedge clk) begin
    if (rst_n && rd_en) begin
      if (addr_q.size() == 0) check("rd_addr_extra", 32'(addr_q.size()), 32'd1);
      else check("rd_addr", 32'({rd_row, rd_col}), 32'(addr_q.pop_front()));
    end
    if (rst_n && value_stb && value_ack) begin
      acc_cnt++;
      if (exp_q.size() == 0) check("value_extra", 32'(exp_q.size()), 32'd1);
      else check("value", value, exp_q.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_drain(input logic t);
    for (int k = 0; k < NN; k++) begin
      int i;
      int j;
      if (t) begin i = k % 2; j = k / 2; end
      else   begin i = k / 2; j = k % 2; end
      exp_q.push_back(elem(i, j));
      addr_q.push_back({i[4:0], j[4:0]});
    end
  endtask

  task automatic start_drain(input logic t, output int c);
    start = 1'b1;
    cfg_transpose = t;
    push_drain(t);
    c = cyc;
    tick();
    start = 1'b0;
    cfg_transpose = 1'b0;
  endtask

  task automatic wait_done(output int c);
    bit seen = 1'b0;
    c = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; c = cyc; end
    end
    check("done_seen", 32'(seen), 32'd1);
    tick();
  endtask

  task automatic wait_stb(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (value_stb) seen = 1'b1;
      else tick();
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int exp_count);
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, "_q_empty"}, 32'(exp_q.size() + addr_q.size()), 32'd0);
  endtask

  initial begin
    int sc, dc, d0, a0;
    bit found;
    rst_n = 1'b0;
    start = 1'b0; cfg_transpose = 1'b0; value_ack = 1'b1;
    start_1 = 1'b0; cfg_transpose_1 = 1'b0; value_ack_1 = 1'b1;
    repeat (3) tick();

    // reset state
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_addr", 32'({rd_row, rd_col}), 32'd0);
    check("rst_value", value, 32'd0);
    check("rst_stb", 32'(value_stb), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst1_outputs", 32'({rd_en_1, value_stb_1, busy_1, done_1}), 32'd0);
    rst_n = 1'b1;
    tick();

    // row-major, ack always high
    d0 = done_cnt;
    start_drain(1'b0, sc);
    wait_done(dc);
    check("t1_latency", 32'(dc - sc + 1), 32'd14);
    check_idle("t1", 4);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // column-major
    d0 = done_cnt;
    start_drain(1'b1, sc);
    wait_done(dc);
    check_idle("t2", 4);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

    // backpressure on the second element
    d0 = done_cnt;
    start_drain(1'b0, sc);
    wait_stb("t3_first_stb");
    tick();
    value_ack = 1'b0;
    wait_stb("t3_second_stb");
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_stb", 32'(value_stb), 32'd1);
      check("t3_hold_value", value, elem(0, 1));
      check("t3_no_rd_en", 32'(rd_en), 32'd0);
      tick();
    end
    value_ack = 1'b1;
    check("t3_still_stb", 32'(value_stb), 32'd1);
    wait_done(dc);
    check_idle("t3", 4);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

    // second start while busy is ignored
    d0 = done_cnt;
    a0 = acc_cnt;
    start_drain(1'b0, sc);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(dc);
    repeat (10) tick();
    check_idle("t4", 4);
    check("t4_accepts", 32'(acc_cnt - a0), 32'd4);
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // reset during the send of the third element
    d0 = done_cnt;
    a0 = acc_cnt;
    start_drain(1'b0, sc);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (value_stb && value == elem(1, 0)) found = 1'b1;
      else tick();
    end
    check("t5_third_send", 32'(found), 32'd1);
    value_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t5_rst_strobes", 32'({rd_en, value_stb, busy, done}), 32'd0);
    check("t5_rst_addr", 32'({rd_row, rd_col}), 32'd0);
    check("t5_rst_value", value, 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    value_ack = 1'b1;
    check("t5_accepts", 32'(acc_cnt - a0), 32'd2);
    exp_q.delete();
    addr_q.delete();
    repeat (3) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    start_drain(1'b0, sc);
    wait_done(dc);
    check_idle("t5_fresh", 4);
    check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);

    // N=1 single element
    start_1 = 1'b1;
    exp1_q.push_back(32'h3F80_0000);
    sc = cyc;
    tick();
    start_1 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (value_stb_1) found = 1'b1;
      else tick();
    end
    check("n1_stb_seen", 32'(found), 32'd1);
    check("n1_value", value_1, exp1_q.pop_front());
    check("n1_addr", 32'({rd_row_1, rd_col_1}), 32'd0);
    tick();
    check("n1_done_after_ack", 32'(done_1), 32'd1);
    check("n1_latency", 32'(cyc - sc + 1), 32'd5);
    check("n1_count", 32'(count_1), 32'd1);
    check("n1_busy", 32'(busy_1), 32'd0);
    tick();
    check("n1_done_pulse", 32'(done_1), 32'd0);
    check("n1_count_hold", 32'(count_1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
